jtframe_dwnld_seq: RTL and testbench



---
 rtl/jtframe_dwnld_seq_if.sv | 24 ++
 rtl/jtframe_dwnld_seq.sv | 164 ++++++++++++++++
 tb/tb_jtframe_dwnld_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_dwnld_seq_if.sv
// Download-side bus bundle: ioctl byte stream in, SDRAM programming port out.
// The sequencer takes the master side because it masters the prog_* write requests.
interface jtframe_dwnld_seq_if;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_bank;
    logic        prog_we;
    logic        prog_rdy;

    modport master (
        input  ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        output prog_addr, prog_data, prog_mask, prog_bank, prog_we
    );

    modport slave (
        output ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        input  prog_addr, prog_data, prog_mask, prog_bank, prog_we
    );
endinterface

// File: rtl/jtframe_dwnld_seq.sv
// ROM download byte stream to SDRAM word writes, with a 4-entry FIFO absorbing back-pressure.
// Optional header diversion is enabled by defining JTFRAME_DWNLD_HEADER_EN.
module jtframe_dwnld_seq #(
    parameter logic [24:0] BA1_START   = 25'h40_0000,
    parameter logic [24:0] BA2_START   = 25'h80_0000,
    parameter logic [24:0] BA3_START   = 25'hC0_0000,
    parameter int unsigned HEADER      = 0,
    parameter int unsigned POST_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       downloading,
    jtframe_dwnld_seq_if.master        bus,
    output logic                       dwnld_busy,
    output logic                       overflow
`ifdef JTFRAME_DWNLD_HEADER_EN
    ,
    output logic [7:0]                 header_byte,
    output logic                       header_wr
`endif
);

`ifdef JTFRAME_DWNLD_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int unsigned TAIL_W = $clog2(POST_CYCLES + 2);

    typedef struct packed {
        logic [1:0]  bank;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t              state;
    entry_t              mem [4];
    entry_t              in_entry;
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          count;
    logic [24:0]         ea, bank_start;
    logic                is_hdr, accept, push, push_ok, pop, empty, full, drop;
    logic                dl_q, drained;
    logic [TAIL_W-1:0]   tail;

    // Input stage: address translation and bank select, consumed directly by the FIFO write.
    always_comb begin
        ea         = bus.ioctl_addr - 25'(HDR_EN ? HEADER : 0);
        is_hdr     = HDR_EN && (32'(bus.ioctl_addr) < HEADER);
        in_entry   = '0;
        bank_start = '0;
        if (ea >= BA3_START) begin
            in_entry.bank = 2'd3;
            bank_start    = BA3_START;
        end else if (ea >= BA2_START) begin
            in_entry.bank = 2'd2;
            bank_start    = BA2_START;
        end else if (ea >= BA1_START) begin
            in_entry.bank = 2'd1;
            bank_start    = BA1_START;
        end
        in_entry.addr = 22'((ea - bank_start) >> 1);
        in_entry.mask = ea[0] ? 2'b01 : 2'b10;
        in_entry.data = bus.ioctl_data;
    end

    always_comb begin
        accept  = downloading && bus.ioctl_wr;
        push    = accept && !is_hdr;
        empty   = (count == 3'd0);
        full    = (count == 3'd4);
        pop     = (state == ST_IDLE) && !empty;
        // A full FIFO still takes the byte when the FSM frees a slot in the same cycle.
        drop    = push && full && !pop;
        push_ok = push && !drop;
        drained = empty && (state == ST_IDLE) && !downloading;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push_ok) - 3'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.prog_addr <= '0;
            bus.prog_data <= '0;
            bus.prog_mask <= '1;
            bus.prog_bank <= '0;
            bus.prog_we   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        bus.prog_addr <= mem[rd_ptr].addr;
                        bus.prog_data <= mem[rd_ptr].data;
                        bus.prog_mask <= mem[rd_ptr].mask;
                        bus.prog_bank <= mem[rd_ptr].bank;
                        bus.prog_we   <= 1'b1;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.prog_rdy) begin
                        bus.prog_we <= 1'b0;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tail counter is held at full value until the stream is drained, then runs down once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            overflow   <= 1'b0;
            tail       <= '0;
            dwnld_busy <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (downloading && !dl_q) overflow <= 1'b0;
            if (drop)                 overflow <= 1'b1;
            if (!drained)             tail <= TAIL_W'(POST_CYCLES);
            else if (tail != '0)      tail <= tail - 1'b1;
            dwnld_busy <= downloading || !empty || (state != ST_IDLE) || (tail != '0);
        end
    end

`ifdef JTFRAME_DWNLD_HEADER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_byte <= '0;
            header_wr   <= 1'b0;
        end else begin
            header_wr <= accept && is_hdr;
            if (accept && is_hdr) header_byte <= bus.ioctl_data;
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_dwnld_seq.sv
// Directed bench for jtframe_dwnld_seq: latency, bank mapping, overflow, busy tail, reset, header.
module tb_jtframe_dwnld_seq;

`ifdef JTFRAME_DWNLD_HEADER_EN
    localparam int unsigned TB_HDR = 4;
`else
    localparam int unsigned TB_HDR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic downloading = 1'b0;
    logic dwnld_busy, overflow;
`ifdef JTFRAME_DWNLD_HEADER_EN
    logic [7:0] header_byte;
    logic       header_wr;
`endif

    int checks = 0;
    int failures = 0;
    int w, n;

    jtframe_dwnld_seq_if bus();

    jtframe_dwnld_seq #(
        .BA1_START   (25'h40_0000),
        .BA2_START   (25'h80_0000),
        .BA3_START   (25'hC0_0000),
        .HEADER      (TB_HDR),
        .POST_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .bus         (bus),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
`ifdef JTFRAME_DWNLD_HEADER_EN
        ,
        .header_byte (header_byte),
        .header_wr   (header_wr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [1:0] bank, input logic [21:0] addr,
                                input logic [1:0] mask, input logic [7:0] data, output int waited);
        waited = 0;
        while (!bus.prog_we && waited < 40) begin
            tick();
            waited++;
        end
        check({tag, "_we"},   32'(bus.prog_we),   32'd1);
        check({tag, "_bank"}, 32'(bus.prog_bank), 32'(bank));
        check({tag, "_addr"}, 32'(bus.prog_addr), 32'(addr));
        check({tag, "_mask"}, 32'(bus.prog_mask), 32'(mask));
        check({tag, "_data"}, 32'(bus.prog_data), 32'(data));
        bus.prog_rdy = 1'b1;
        tick();
        bus.prog_rdy = 1'b0;
        check({tag, "_we_fall"}, 32'(bus.prog_we), 32'd0);
    endtask

    task automatic count_we(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (bus.prog_we) cnt++;
        end
    endtask

    initial begin
        bus.ioctl_addr = '0;
        bus.ioctl_data = '0;
        bus.ioctl_wr   = 1'b0;
        bus.prog_rdy   = 1'b0;

        // reset values
        repeat (2) tick();
        check("rst_addr",  32'(bus.prog_addr), 32'd0);
        check("rst_data",  32'(bus.prog_data), 32'd0);
        check("rst_mask",  32'(bus.prog_mask), 32'd3);
        check("rst_bank",  32'(bus.prog_bank), 32'd0);
        check("rst_we",    32'(bus.prog_we),   32'd0);
        check("rst_busy",  32'(dwnld_busy),    32'd0);
        check("rst_ovf",   32'(overflow),      32'd0);
`ifdef JTFRAME_DWNLD_HEADER_EN
        check("rst_hwr",   32'(header_wr),     32'd0);
        check("rst_hbyte", 32'(header_byte),   32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // strobes outside the download window are ignored
        strobe(25'(32'h10 + TB_HDR), 8'h33);
        count_we(8, n);
        check("ign_we",   32'(n),          32'd0);
        check("ign_busy", 32'(dwnld_busy), 32'd0);

        // single byte: latency and hold until ack
        downloading = 1'b1;
        repeat (2) tick();
        strobe(25'(32'h3 + TB_HDR), 8'h5A);
        check("sb_we_n1", 32'(bus.prog_we), 32'd0);
        tick();
        check("sb_we_n2", 32'(bus.prog_we),   32'd1);
        check("sb_addr",  32'(bus.prog_addr), 32'd1);
        check("sb_mask",  32'(bus.prog_mask), 32'b01);
        check("sb_bank",  32'(bus.prog_bank), 32'd0);
        check("sb_data",  32'(bus.prog_data), 32'h5A);
        check("sb_busy",  32'(dwnld_busy),    32'd1);
        tick();
        check("sb_hold1_we",   32'(bus.prog_we),   32'd1);
        check("sb_hold1_data", 32'(bus.prog_data), 32'h5A);
        tick();
        check("sb_hold2_we",   32'(bus.prog_we),   32'd1);
        check("sb_hold2_addr", 32'(bus.prog_addr), 32'd1);
        bus.prog_rdy = 1'b1;
        tick();
        bus.prog_rdy = 1'b0;
        check("sb_we_fall", 32'(bus.prog_we), 32'd0);

        // bank mapping, back-to-back spacing of 3 cycles
        strobe(25'(32'h3F_FFFF + TB_HDR), 8'hB0);
        strobe(25'(32'h40_0000 + TB_HDR), 8'hB1);
        strobe(25'(32'h80_0001 + TB_HDR), 8'hB2);
        strobe(25'(32'hC0_0002 + TB_HDR), 8'hB3);
        expect_write("bk0", 2'd0, 22'h1F_FFFF, 2'b01, 8'hB0, w);
        expect_write("bk1", 2'd1, 22'h0,       2'b10, 8'hB1, w);
        check("bk1_gap", 32'(w), 32'd2);
        expect_write("bk2", 2'd2, 22'h0,       2'b01, 8'hB2, w);
        check("bk2_gap", 32'(w), 32'd2);
        expect_write("bk3", 2'd3, 22'h1,       2'b10, 8'hB3, w);
        check("bk3_gap", 32'(w), 32'd2);
        check("bk_ovf",  32'(overflow), 32'd0);

        // overflow: one in WAIT, four buffered, sixth dropped
        for (int i = 0; i < 6; i++) strobe(25'(32'h100 + i + TB_HDR), 8'(8'h10 + i));
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++)
            expect_write($sformatf("ovf%0d", i), 2'd0, 22'(32'h80 + i / 2),
                         (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'h10 + i), w);
        count_we(10, n);
        check("ovf_no6th",  32'(n),        32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        downloading = 1'b0;
        tick();
        check("ovf_fall_keep", 32'(overflow), 32'd1);
        downloading = 1'b1;
        tick();
        check("ovf_clear", 32'(overflow), 32'd0);

        // busy tail after the download window closes with two pending
        strobe(25'(32'h200 + TB_HDR), 8'hC0);
        strobe(25'(32'h201 + TB_HDR), 8'hC1);
        downloading = 1'b0;
        check("tail_pend", 32'(dwnld_busy), 32'd1);
        expect_write("tail0", 2'd0, 22'h100, 2'b10, 8'hC0, w);
        check("tail_mid", 32'(dwnld_busy), 32'd1);
        expect_write("tail1", 2'd0, 22'h100, 2'b01, 8'hC1, w);
        repeat (15) tick();
        check("tail_hold", 32'(dwnld_busy), 32'd1);
        n = 0;
        while (dwnld_busy && n < 10) begin
            tick();
            n++;
        end
        check("tail_fall", 32'(dwnld_busy), 32'd0);

        // reset during WAIT abandons the write
        downloading = 1'b1;
        tick();
        strobe(25'(32'h300 + TB_HDR), 8'h77);
        n = 0;
        while (!bus.prog_we && n < 10) begin
            tick();
            n++;
        end
        check("mrst_pre_we", 32'(bus.prog_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_we",   32'(bus.prog_we),   32'd0);
        check("mrst_busy", 32'(dwnld_busy),    32'd0);
        check("mrst_mask", 32'(bus.prog_mask), 32'd3);
        check("mrst_addr", 32'(bus.prog_addr), 32'd0);
        downloading = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        count_we(10, n);
        check("mrst_no_write", 32'(n),          32'd0);
        check("mrst_idle",     32'(dwnld_busy), 32'd0);

`ifdef JTFRAME_DWNLD_HEADER_EN
        // header bytes diverted, payload offset by the header length
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            strobe(25'(i), 8'(8'hA0 + i));
            check($sformatf("hdr%0d_wr", i),   32'(header_wr),   32'd1);
            check($sformatf("hdr%0d_byte", i), 32'(header_byte), 32'(8'hA0 + i));
        end
        strobe(25'd4, 8'hA4);
        check("hdr_end_wr", 32'(header_wr), 32'd0);
        strobe(25'd5, 8'hA5);
        expect_write("hdrp0", 2'd0, 22'h0, 2'b10, 8'hA4, w);
        expect_write("hdrp1", 2'd0, 22'h0, 2'b01, 8'hA5, w);
        count_we(10, n);
        check("hdr_no_extra", 32'(n), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
